// File: rtl/lstm_pkg.sv
// lstm_pkg: shared definitions for the LSTM datapath blocks.
//   - state_e       : gate MAC sequencer states (ACC accumulating, OUT holding)
//   - acc_width()   : accumulator width for N signed DATA_WIDTH x DATA_WIDTH products
//   - DATA_WIDTH_DEF, FRACT_WIDTH_DEF : default fixed-point format (Q7.8)
package lstm_pkg;

    localparam int DATA_WIDTH_DEF  = 16;
    localparam int FRACT_WIDTH_DEF = 8;

    typedef enum logic {
        ACC = 1'b0,
        OUT = 1'b1
    } state_e;

    // Full-precision sum of n products of two dw-bit signed values.
    function automatic int acc_width(input int dw, input int n);
        return 2 * dw + $clog2(n);
    endfunction

endpackage

// File: rtl/gate_mac_seq_if.sv
// gate_mac_seq_if: term-input and result-output handshakes of the gate MAC.
//   clr                       : synchronous abort from the controller
//   in_valid/in_ready         : term handshake carrying in_v, in_w, in_b
//   out_valid/out_ready       : result handshake carrying out_data
//   master modport : upstream/consumer side; slave modport : the MAC block.
interface gate_mac_seq_if #(
    parameter int DATA_WIDTH = lstm_pkg::DATA_WIDTH_DEF
);
    logic                  clr;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_v;
    logic [DATA_WIDTH-1:0] in_w;
    logic [DATA_WIDTH-1:0] in_b;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;

    modport master (
        output clr, in_valid, in_v, in_w, in_b, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  clr, in_valid, in_v, in_w, in_b, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/fxp_narrow.sv
// fxp_narrow: combinational narrowing of a wide signed fixed-point value to OUT_W bits.
//   din  : IN_W-bit signed value (IN_W > OUT_W)
//   dout : OUT_W-bit result
// Macro SATURATE_EN: defined -> clamp to the signed OUT_W range;
//                    undefined -> keep the low OUT_W bits (wrap-around).
module fxp_narrow #(
    parameter int IN_W  = 33,
    parameter int OUT_W = 16
) (
    input  logic signed [IN_W-1:0]  din,
    output logic        [OUT_W-1:0] dout
);
`ifdef SATURATE_EN
    localparam logic signed [IN_W-1:0] MAX_V = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W-1:0] MIN_V = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    always_comb begin
        dout = din[OUT_W-1:0];
        if (din > MAX_V)
            dout = MAX_V[OUT_W-1:0];
        else if (din < MIN_V)
            dout = MIN_V[OUT_W-1:0];
    end
`else
    logic unused_hi;
    assign unused_hi = ^din[IN_W-1:OUT_W];
    assign dout      = din[OUT_W-1:0];
`endif
endmodule

// File: rtl/gate_mac_seq.sv
// gate_mac_seq: sequential gate pre-activation unit, out = sum_k W[k]*v[k] + b.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : gate_mac_seq_if.slave (clr, term handshake in, result handshake out)
// One term per accepted cycle is accumulated at full precision; the last term
// triggers a single arithmetic rescale, bias add and narrowing into out_data.
// Macro SATURATE_EN (via fxp_narrow): clamp instead of wrap on narrowing.
module gate_mac_seq
    import lstm_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int FRACT_WIDTH = FRACT_WIDTH_DEF,
    parameter int N_TERMS     = 2
) (
    input logic          clk,
    input logic          rst,
    gate_mac_seq_if.slave bus
);
    localparam int ACC_W = acc_width(DATA_WIDTH, N_TERMS);
    localparam int CNT_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_TERMS - 1);

    state_e                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;

    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_W-1:0]        prod_ext, b_ext, sum_full, rescaled;
    logic [DATA_WIDTH-1:0]          r_narrow;

    assign prod     = signed'(bus.in_v) * signed'(bus.in_w);
    assign prod_ext = ACC_W'(prod);
    assign b_ext    = ACC_W'(signed'(bus.in_b));
    assign sum_full = acc_q + prod_ext;
    // Arithmetic shift: rescale rounds toward minus infinity.
    assign rescaled = (sum_full >>> FRACT_WIDTH) + b_ext;

    fxp_narrow #(
        .IN_W  (ACC_W),
        .OUT_W (DATA_WIDTH)
    ) u_narrow (
        .din  (rescaled),
        .dout (r_narrow)
    );

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (bus.clr) begin
            // Abort wins over a same-cycle term or result handshake.
            state_d     = ACC;
            acc_d       = '0;
            cnt_d       = '0;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                ACC: begin
                    if (bus.in_valid) begin
                        if (cnt_q == LAST) begin
                            out_data_d  = r_narrow;
                            out_valid_d = 1'b1;
                            state_d     = OUT;
                        end else begin
                            acc_d = sum_full;
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        out_valid_d = 1'b0;
                        acc_d       = '0;
                        cnt_d       = '0;
                        state_d     = ACC;
                    end
                end
                default: state_d = ACC;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ACC;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // in_ready depends on state only, never on out_ready.
    assign bus.in_ready  = (state_q == ACC);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_gate_mac_seq.sv
// tb_gate_mac_seq: directed self-checking bench for gate_mac_seq
// (DATA_WIDTH=16, FRACT_WIDTH=8, N_TERMS=2). Honours SATURATE_EN for the
// overflow expectation.
module tb_gate_mac_seq;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    gate_mac_seq_if #(.DATA_WIDTH(16)) bus ();

    gate_mac_seq #(
        .DATA_WIDTH  (16),
        .FRACT_WIDTH (8),
        .N_TERMS     (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

`ifdef SATURATE_EN
    localparam logic [15:0] EXP_OVF = 16'h7FFF;
`else
    localparam logic [15:0] EXP_OVF = 16'hFE00;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One term presented for exactly one cycle (accepted when in_ready=1).
    task automatic push(input logic [15:0] v, input logic [15:0] w, input logic [15:0] b);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_v     = v;
        bus.in_w     = w;
        bus.in_b     = b;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Wait (bounded) for a result, check it, complete the handshake.
    task automatic take(input logic [15:0] exp, input string tag);
        int k = 0;
        while (!bus.out_valid && k < 8) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_valid"}, bus.out_valid, 1);
        chk({tag, "_data"}, bus.out_data, exp);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({tag, "_drop"}, bus.out_valid, 0);
        chk({tag, "_rdy"}, bus.in_ready, 1);
    endtask

    initial begin
        rst           = 1'b1;
        bus.clr       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_v      = '0;
        bus.in_w      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        rst = 1'b0;

        // Basic sum: 0.5 + 0.5 + 0.125 = 1.125
        push(16'h0100, 16'h0080, 16'h0000);
        chk("basic_mid_valid", bus.out_valid, 0);
        chk("basic_mid_ready", bus.in_ready, 1);
        push(16'h0200, 16'h0040, 16'h0020);
        chk("basic_lat_valid", bus.out_valid, 1);
        chk("basic_lat_ready", bus.in_ready, 0);
        take(16'h0120, "basic");

        // Floor rounding of negative values
        push(16'hFFFF, 16'h0080, 16'h0000);
        push(16'h0000, 16'h0000, 16'h0000);
        take(16'hFFFF, "floor_a");
        push(16'hFF00, 16'h0100, 16'h0000);
        push(16'h0000, 16'h0000, 16'h0000);
        take(16'hFF00, "floor_b");

        // Overflow: 2 * 0x3FFF0001 >>> 8 = 0x7FFE00
        push(16'h7FFF, 16'h7FFF, 16'h0000);
        push(16'h7FFF, 16'h7FFF, 16'h0000);
        take(EXP_OVF, "ovf");

        // Backpressure with junk on the input side
        push(16'h0100, 16'h0080, 16'h0000);
        push(16'h0200, 16'h0040, 16'h0020);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_v     = 16'h7FFF;
            bus.in_w     = 16'h7FFF;
            @(negedge clk);
            chk("bp_data", bus.out_data, 16'h0120);
            chk("bp_valid", bus.out_valid, 1);
            chk("bp_in_ready", bus.in_ready, 0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("bp_release_valid", bus.out_valid, 0);
        chk("bp_release_ready", bus.in_ready, 1);
        // 3.0 * 1.0 + 1/256: proves the held junk was not accumulated
        push(16'h0300, 16'h0100, 16'h0000);
        push(16'h0000, 16'h0000, 16'h0001);
        take(16'h0301, "bp_next");

        // Abort on the first accepted term
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_v     = 16'h7FFF;
        bus.in_w     = 16'h7FFF;
        bus.clr      = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.clr      = 1'b0;
        chk("abort1_ready", bus.in_ready, 1);
        push(16'h0100, 16'h0080, 16'h0000);
        chk("abort1_cnt", bus.out_valid, 0);
        push(16'h0200, 16'h0040, 16'h0020);
        take(16'h0120, "abort1");

        // Abort during OUT with out_ready high
        push(16'h0100, 16'h0100, 16'h0000);
        push(16'h0000, 16'h0000, 16'h0000);
        chk("abort2_pre", bus.out_valid, 1);
        bus.out_ready = 1'b1;
        bus.clr       = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.clr       = 1'b0;
        chk("abort2_valid", bus.out_valid, 0);
        chk("abort2_ready", bus.in_ready, 1);
        push(16'h0080, 16'h0200, 16'h0000);
        push(16'h0000, 16'h0000, 16'h0005);
        take(16'h0105, "abort2_next");

        // Asynchronous reset mid-accumulation
        push(16'h0100, 16'h0080, 16'h0000);
        #2 rst = 1'b1;
        #1;
        chk("arst_acc_valid", bus.out_valid, 0);
        chk("arst_acc_data", bus.out_data, 0);
        chk("arst_acc_ready", bus.in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        push(16'h0100, 16'h0080, 16'h0000);
        chk("arst_cnt", bus.out_valid, 0);
        push(16'h0200, 16'h0040, 16'h0020);
        take(16'h0120, "arst_next");

        // Asynchronous reset mid-OUT
        push(16'h0100, 16'h0100, 16'h0000);
        push(16'h0000, 16'h0000, 16'h0000);
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", bus.out_valid, 0);
        chk("arst_out_data", bus.out_data, 0);
        chk("arst_out_ready", bus.in_ready, 1);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
